mem_arbiter_nch: RTL and testbench
==================================

// Module: mem_arbiter_nch
// PURPOSE
//  N-channel byte-serial memory controller for the out-of-order core; successor to the fixed two-port (ICache + LSB) controller.
//  Arbitrates up to NUM_CH word/half/byte requests onto the 8-bit RAM/IO bus, one access in flight.
//  Adds round-robin or fixed priority, per-channel flush masking and rdy-pause resync.
//  Sits between the requesters (ICache, LSB, future prefetch/DMA) and the top-level mem_* pins.
// PARAMETERS
//  NUM_CH      2        number of request channels (1..8)
//  ADDR_W      32       address width; only [17:0] reaches RAM decoding
//  RR_EN       1        1 = round-robin grant; 0 = fixed priority, lowest index wins
//  FLUSH_MASK  'b01     bit i set = channel i read requests are killed by jump_flag
// PORTS
//  clk             in   1             system clock
//  rst             in   1             synchronous reset, active high
//  rdy             in   1             pause when low
//  jump_flag       in   1             mispredict flush
//  ch_valid        in   NUM_CH        request valid, held high until ch_done
//  ch_wr           in   NUM_CH        1 = write, 0 = read
//  ch_size         in   3*NUM_CH      bytes: 1, 2 or 4
//  ch_addr         in   ADDR_W*NUM_CH byte address
//  ch_wdata        in   32*NUM_CH     store data, little-endian
//  ch_done         out  NUM_CH        one-cycle completion pulse
//  ch_rdata        out  32            load data, zero-filled above size; valid with any ch_done
//  mem_din         in   8             RAM/IO read byte, one cycle after address
//  mem_dout        out  8             write byte
//  mem_a           out  32            byte address
//  mem_wr          out  1             1 = write
//  io_buffer_full  in   1             UART tx buffer full
// BEHAVIOUR
//  - Reset: state IDLE; ch_done=0, ch_rdata=0, mem_a=0, mem_dout=0, mem_wr=0, rr pointer=0, byte counter=0.
//  - IDLE: bus idle, mem_wr=0, mem_a=0. At edge E0 the arbiter picks a winner among valid, non-killed channels.
//    The winner's addr/size/wr/wdata are latched, byte 0 is driven and the state moves to BUSY.
//  - Read of n bytes: byte k address driven after edge Ek. mem_din for byte k is sampled at E(k+2).
//    At E(n+1): ch_rdata is assembled, ch_done[i]=1 for one cycle, state returns to IDLE.
//  - Write of n bytes: byte k driven after Ek with mem_wr=1, mem_dout=wdata[8k+7:8k]. ch_done pulses after E(n-1).
//  - One idle cycle follows every completion; back-to-back accepts are one cycle apart.
//  - Round-robin: after a grant to i, priority starts at i+1 mod NUM_CH. Pointer unchanged when no grant.
//  - IO: addr[17:16]==2'b11 with wr=1 and io_buffer_full=1: hold the byte with mem_wr=0 until the flag drops.
//  - Flush: jump_flag=1 while BUSY on a read of a FLUSH_MASK channel aborts it; no ch_done, IDLE next cycle.
//    In IDLE, jump_flag masks masked channels from arbitration that cycle.
//    Writes and unmasked channels are never aborted.
//  - rdy=0: all state, counters and outputs frozen, except mem_wr is forced 0.
//    On the first rdy=1 cycle of a read, re-drive the address of the next byte to be sampled; adds one cycle.
//  - Simultaneous ch_valid drop and grant is illegal (requester must hold).
//  - size values other than 1/2/4 are treated as 4.
//  - rst mid-transfer: immediate return to reset state, partial write is not completed.
// STRUCTURE
//  - Shared package/config.v: MEM_SZ_B=1, MEM_SZ_H=2, MEM_SZ_W=4, IO_SEL=2'b11, state encodings IDLE/BUSY/RESYNC.
//  - Sub-module rr_arbiter (NUM_CH, RR_EN): request vector + pointer -> one-hot grant and next pointer.
//  - Top: 3-state FSM, 2-bit byte counter, 32-bit assembly register.
// TESTING
//  1. Ch0 word read 0x100, RAM 13 05 00 00 -> ch_done[0] after E5, ch_rdata=0x00000513; mem_a 0x100..0x103 after E0..E3.
//  2. Ch1 half write 0x204 data 0xABCD1234 -> mem_dout 0x34@0x204, 0x12@0x205; ch_done[1] after E1; mem_wr=0 after E2.
//  3. Ch0 and ch1 valid continuously, RR_EN=1 -> grants alternate 0,1,0,1; with RR_EN=0, ch0 always wins.
//  4. Ch0 read in flight, jump_flag pulse at E2 -> no ch_done[0], IDLE next cycle. Same pulse during a ch1 write -> write completes.
//  5. Byte write 0x30000 with io_buffer_full=1 for 5 cycles -> mem_wr=0 throughout; mem_wr=1 the cycle after the flag clears.
//  6. rdy=0 for 3 cycles during byte 2 of a word read -> frozen outputs; resync re-drives byte 2 address; rdata correct, one cycle late.

Source files
------------

// File: rtl/mem_arbiter_nch_pkg.sv
// mem_arbiter_nch_pkg: shared sizes, IO decode and FSM encodings for the byte-serial memory arbiter
package mem_arbiter_nch_pkg;
   localparam logic [2:0] MEM_SZ_B = 3'd1;
   localparam logic [2:0] MEM_SZ_H = 3'd2;
   localparam logic [2:0] MEM_SZ_W = 3'd4;
   localparam logic [1:0] IO_SEL = 2'b11;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESYNC = 2'd2;
   // Index of the final byte; any unsupported size behaves as a word.
   function automatic logic [1:0] last_byte(input logic [2:0] size);
      return size == MEM_SZ_B ? 2'd0 : size == MEM_SZ_H ? 2'd1 : 2'd3;
   endfunction
endpackage

// File: rtl/mem_arbiter_nch_rr_arbiter.sv
// mem_arbiter_nch_rr_arbiter: one-hot grant from a request vector, round-robin from ptr or fixed lowest-index
module mem_arbiter_nch_rr_arbiter #(
   parameter int NUM_CH = 2,
   parameter bit RR_EN = 1'b1,
   parameter int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [PW-1:0]     ptr,
   output logic [NUM_CH-1:0] gnt,
   output logic [PW-1:0]     idx,
   output logic [PW-1:0]     nxt_ptr
);
   // Scan from the farthest candidate back to the base so the nearest requester overwrites last.
   always_comb begin : pick
      int c;
      gnt = '0;
      idx = '0;
      nxt_ptr = ptr;
      c = 0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         c = (RR_EN ? int'(ptr) : 0) + k;
         if (c >= NUM_CH) c -= NUM_CH;
         if (req[PW'(c)]) begin
            gnt = NUM_CH'(1) << c;
            idx = PW'(c);
            nxt_ptr = (c == NUM_CH - 1) ? '0 : PW'(c + 1);
         end
      end
   end
endmodule

// File: rtl/mem_arbiter_nch.sv
// mem_arbiter_nch: N-channel arbiter serialising word/half/byte requests onto the 8-bit RAM/IO bus
module mem_arbiter_nch
   import mem_arbiter_nch_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 32,
   parameter bit RR_EN = 1'b1,
   parameter logic [NUM_CH-1:0] FLUSH_MASK = NUM_CH'(1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     jump_flag,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH-1:0]        ch_wr,
   input  logic [3*NUM_CH-1:0]      ch_size,
   input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
   input  logic [32*NUM_CH-1:0]     ch_wdata,
   output logic [NUM_CH-1:0]        ch_done,
   output logic [31:0]              ch_rdata,
   input  logic [7:0]               mem_din,
   output logic [7:0]               mem_dout,
   output logic [31:0]              mem_a,
   output logic                     mem_wr,
   input  logic                     io_buffer_full
);
   localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   logic [1:0] state, cnt, rcnt, last;
   logic arm, wr, hold, take, flush;
   logic [PW-1:0] ptr, sel, idx, nxt_ptr;
   logic [ADDR_W-1:0] addr, w_addr;
   logic [31:0] wdata, rbuf, nbuf;
   logic [NUM_CH-1:0] req, gnt;
   logic [2:0] w_size;
   assign req = ch_valid & ~(jump_flag ? FLUSH_MASK & ~ch_wr : '0);
   mem_arbiter_nch_rr_arbiter #(.NUM_CH(NUM_CH), .RR_EN(RR_EN), .PW(PW)) u_arb (
      .req(req), .ptr(ptr), .gnt(gnt), .idx(idx), .nxt_ptr(nxt_ptr)
   );
   assign w_addr = ch_addr[idx*ADDR_W +: ADDR_W];
   assign w_size = ch_size[idx*3 +: 3];
   // The completion cycle itself counts as the idle gap, so no grant while ch_done is up.
   assign take = state == IDLE && rdy && ch_done == '0 && req != '0;
   assign flush = jump_flag && state != IDLE && !wr && FLUSH_MASK[sel];
   assign nbuf = rbuf | ({24'd0, mem_din} << {rcnt, 3'b000});
   // On resume, re-issue the byte whose data the pause dropped.
   assign mem_a = state == IDLE ? '0 : 32'(addr) + {30'd0, (state == RESYNC && rdy) ? rcnt : cnt};
   assign mem_wr = state == BUSY && wr && rdy && !hold;
   assign mem_dout = (state == BUSY && wr) ? 8'(wdata >> {cnt, 3'b000}) : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         rcnt <= '0;
         last <= '0;
         arm <= 1'b0;
         wr <= 1'b0;
         hold <= 1'b0;
         ptr <= '0;
         sel <= '0;
         addr <= '0;
         wdata <= '0;
         rbuf <= '0;
         ch_done <= '0;
         ch_rdata <= '0;
      end else if (take) begin
         state <= BUSY;
         ptr <= nxt_ptr;
         sel <= idx;
         addr <= w_addr;
         wr <= ch_wr[idx];
         last <= last_byte(w_size);
         wdata <= ch_wdata[idx*32 +: 32];
         hold <= ch_wr[idx] && w_addr[17:16] == IO_SEL && io_buffer_full;
         cnt <= '0;
         rcnt <= '0;
         arm <= 1'b0;
         rbuf <= '0;
         ch_done <= (ch_wr[idx] && last_byte(w_size) == 2'd0) ? gnt : '0;
      end else if (flush) begin
         state <= IDLE;
         ch_done <= '0;
      end else if (!rdy) begin
         if (state == BUSY && !wr) state <= RESYNC;
      end else if (state == RESYNC) begin
         state <= BUSY;
      end else if (state == BUSY && wr) begin
         ch_done <= '0;
         hold <= addr[17:16] == IO_SEL && io_buffer_full;
         if (!hold) begin
            if (cnt == last) state <= IDLE;
            else begin
               cnt <= cnt + 2'd1;
               if (2'(cnt + 2'd1) == last) ch_done <= NUM_CH'(1) << sel;
            end
         end
      end else if (state == BUSY) begin
         arm <= 1'b1;
         ch_done <= '0;
         if (cnt != last) cnt <= cnt + 2'd1;
         if (arm) begin
            rbuf <= nbuf;
            rcnt <= rcnt + 2'd1;
            if (rcnt == last) begin
               state <= IDLE;
               ch_done <= NUM_CH'(1) << sel;
               ch_rdata <= nbuf;
            end
         end
      end else begin
         ch_done <= '0;
      end
   end
endmodule

// File: tb/tb_mem_arbiter_nch.sv
// tb_mem_arbiter_nch: directed checks of timing, arbitration, flush, IO hold, pause resync and reset
module tb_mem_arbiter_nch;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, rdy, jump_flag, io_buffer_full;
   logic [1:0] ch_valid, ch_wr, ch_done, fp_done;
   logic [5:0] ch_size;
   logic [63:0] ch_addr, ch_wdata;
   logic [31:0] ch_rdata, fp_rdata, mem_a, fp_a;
   logic [7:0] mem_din, mem_dout, fp_dout;
   logic mem_wr, fp_wr;
   int errors = 0;
   int checks = 0;

   mem_arbiter_nch #(.NUM_CH(2), .ADDR_W(32), .RR_EN(1'b1), .FLUSH_MASK(2'b01)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .jump_flag(jump_flag), .ch_valid(ch_valid), .ch_wr(ch_wr),
      .ch_size(ch_size), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_done(ch_done), .ch_rdata(ch_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
   );
   mem_arbiter_nch #(.NUM_CH(2), .ADDR_W(32), .RR_EN(1'b0), .FLUSH_MASK(2'b01)) dut_fp (
      .clk(clk), .rst(rst), .rdy(rdy), .jump_flag(jump_flag), .ch_valid(ch_valid), .ch_wr(ch_wr),
      .ch_size(ch_size), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_done(fp_done), .ch_rdata(fp_rdata),
      .mem_din(mem_din), .mem_dout(fp_dout), .mem_a(fp_a), .mem_wr(fp_wr), .io_buffer_full(io_buffer_full)
   );

   function automatic logic [7:0] rom(input logic [31:0] a);
      return a == 32'h100 ? 8'h13 : a == 32'h101 ? 8'h05 : 8'h00;
   endfunction
   always @(posedge clk) mem_din <= rom(mem_a);

   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic req(input int c, input logic w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
      ch_wr[c] = w;
      ch_size[c*3 +: 3] = s;
      ch_addr[c*32 +: 32] = a;
      ch_wdata[c*32 +: 32] = d;
      ch_valid[c] = 1'b1;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; jump_flag = 1'b0; io_buffer_full = 1'b0;
      ch_valid = '0; ch_wr = '0; ch_size = '0; ch_addr = '0; ch_wdata = '0;
      step(); step();
      chk("rst_done", ch_done, 0);
      chk("rst_rdata", ch_rdata, 0);
      chk("rst_a", mem_a, 0);
      chk("rst_wr", mem_wr, 0);
      chk("rst_dout", mem_dout, 0);
      rst = 1'b0;
      step();
      // word read 0x100
      req(0, 1'b0, 3'd4, 32'h100, 32'h0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("rd_addr", mem_a, 32'h100 + k);
         chk("rd_nodone", ch_done, 0);
      end
      step();
      chk("rd_wait", ch_done, 0);
      step();
      chk("rd_done", ch_done, 2'b01);
      chk("rd_data", ch_rdata, 32'h0000_0513);
      chk("rd_idle_a", mem_a, 0);
      ch_valid[0] = 1'b0;
      step();
      chk("rd_pulse", ch_done, 0);
      // byte read: zero-filled, done after E2
      req(0, 1'b0, 3'd1, 32'h100, 32'h0);
      step(); step();
      chk("rb_wait", ch_done, 0);
      step();
      chk("rb_done", ch_done, 2'b01);
      chk("rb_data", ch_rdata, 32'h0000_0013);
      ch_valid[0] = 1'b0;
      step();
      // half write 0x204
      req(1, 1'b1, 3'd2, 32'h204, 32'hABCD_1234);
      step();
      chk("hw_a0", mem_a, 32'h204);
      chk("hw_d0", mem_dout, 8'h34);
      chk("hw_wr0", mem_wr, 1);
      chk("hw_nodone", ch_done, 0);
      step();
      chk("hw_a1", mem_a, 32'h205);
      chk("hw_d1", mem_dout, 8'h12);
      chk("hw_done", ch_done, 2'b10);
      ch_valid[1] = 1'b0;
      step();
      chk("hw_wr_off", mem_wr, 0);
      chk("hw_pulse", ch_done, 0);
      step();
      // both channels byte-writing continuously
      req(0, 1'b1, 3'd1, 32'h300, 32'h11);
      req(1, 1'b1, 3'd1, 32'h310, 32'h22);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rr_grant", ch_done, (i % 2) ? 2'b10 : 2'b01);
         chk("fp_grant", fp_done, 2'b01);
         step();
         chk("rr_gap", ch_done, 0);
      end
      ch_valid = '0;
      step(); step();
      // jump masks a flushable read in IDLE, then aborts it in flight
      req(0, 1'b0, 3'd4, 32'h100, 32'h0);
      jump_flag = 1'b1;
      step();
      chk("jmask_a", mem_a, 0);
      jump_flag = 1'b0;
      step();
      chk("jmask_grant", mem_a, 32'h100);
      step();
      jump_flag = 1'b1;
      step();
      jump_flag = 1'b0;
      ch_valid[0] = 1'b0;
      chk("flush_idle", mem_a, 0);
      chk("flush_nodone", ch_done, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("flush_quiet", ch_done, 0);
      end
      // ch1 write ignores jump
      req(1, 1'b1, 3'd2, 32'h208, 32'h0000_5678);
      step();
      chk("jw_d0", mem_dout, 8'h78);
      jump_flag = 1'b1;
      step();
      jump_flag = 1'b0;
      chk("jw_done", ch_done, 2'b10);
      chk("jw_d1", mem_dout, 8'h56);
      chk("jw_wr1", mem_wr, 1);
      ch_valid[1] = 1'b0;
      step();
      chk("jw_end", mem_wr, 0);
      step();
      // IO byte write held while the UART buffer is full
      io_buffer_full = 1'b1;
      req(1, 1'b1, 3'd1, 32'h30000, 32'h41);
      step();
      chk("io_a", mem_a, 32'h30000);
      ch_valid[1] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) step();
         chk("io_hold", mem_wr, 0);
      end
      io_buffer_full = 1'b0;
      #1;
      chk("io_still", mem_wr, 0);
      step();
      chk("io_wr", mem_wr, 1);
      chk("io_d", mem_dout, 8'h41);
      step();
      chk("io_end", mem_wr, 0);
      step();
      // pause during a word read, then resync
      req(0, 1'b0, 3'd4, 32'h100, 32'h0);
      step(); step(); step(); step();
      chk("ps_a3", mem_a, 32'h103);
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("ps_frozen", mem_a, 32'h103);
         chk("ps_nodone", ch_done, 0);
      end
      rdy = 1'b1;
      #1;
      chk("ps_resync", mem_a, 32'h102);
      step();
      chk("ps_a_back", mem_a, 32'h103);
      step();
      chk("ps_late", ch_done, 0);
      step();
      chk("ps_done", ch_done, 2'b01);
      chk("ps_data", ch_rdata, 32'h0000_0513);
      ch_valid[0] = 1'b0;
      step();
      // reset in the middle of a word write
      req(0, 1'b1, 3'd4, 32'h400, 32'hDDCC_BBAA);
      step();
      chk("mr_d0", mem_dout, 8'hAA);
      step();
      chk("mr_d1", mem_dout, 8'hBB);
      rst = 1'b1;
      step();
      ch_valid[0] = 1'b0;
      rst = 1'b0;
      chk("mr_wr", mem_wr, 0);
      chk("mr_a", mem_a, 0);
      chk("mr_done", ch_done, 0);
      step();
      chk("mr_quiet", mem_wr, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
